// File: rtl/fir_avg_pkg.sv
// Shared types and elaboration helpers for the moving-average FIR.
package fir_avg_pkg;

  typedef enum logic {
    MODE_SUM = 1'b0,
    MODE_AVG = 1'b1
  } out_mode_e;

  // One valid-pipeline stage: result-complete flag plus the mode it was captured with.
  typedef struct packed {
    logic      valid;
    out_mode_e mode;
  } vstage_t;

  // Width of adder-tree level j for W-bit input samples.
  function automatic int unsigned level_width(input int unsigned w, input int unsigned j);
    return w + j;
  endfunction

  // Window length must be a power of two in 2..64.
  function automatic bit taps_ok(input int unsigned t);
    return (t >= 2) && (t <= 64) && ((t & (t - 1)) == 0);
  endfunction

endpackage

// File: rtl/fir_avg_pipe_if.sv
// Streaming sample/result bundle for fir_avg_pipe.
interface fir_avg_pipe_if #(
  parameter int unsigned W    = 16,
  parameter int unsigned TAPS = 4
);
  localparam int unsigned L = $clog2(TAPS);

  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           avg_mode;
  logic           flush;
  logic           out_valid;
  logic [W+L-1:0] out_data;
  logic           window_full;

  modport master (
    output in_valid, in_data, avg_mode, flush,
    input  out_valid, out_data, window_full
  );

  modport slave (
    input  in_valid, in_data, avg_mode, flush,
    output out_valid, out_data, window_full
  );
endinterface

// File: rtl/fir_avg_pipe_add_level.sv
// One registered level of the balanced adder tree: PAIRS pairwise sums, each one bit wider.
module fir_add_level #(
  parameter int unsigned IW    = 16,
  parameter int unsigned PAIRS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [2*PAIRS*IW-1:0]   din,
  output logic [PAIRS*(IW+1)-1:0] dout
);

  // Register the pairwise sums; hold when not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (en) begin
      for (int unsigned p = 0; p < PAIRS; p++) begin
        dout[p*(IW+1) +: (IW+1)] <= {1'b0, din[(2*p)*IW +: IW]}
                                  + {1'b0, din[(2*p+1)*IW +: IW]};
      end
    end
  end

endmodule

// File: rtl/fir_avg_pipe.sv
// N-tap unsigned moving-average FIR: sample delay line, pipelined adder tree,
// per-sample choice of window sum or round-half-up average.
module fir_avg_pipe
  import fir_avg_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned TAPS = 4
) (
  input logic           clk,
  input logic           reset,
  fir_avg_pipe_if.slave bus
);
  localparam int unsigned L    = $clog2(TAPS);
  localparam int unsigned CW   = $clog2(TAPS + 1);
  localparam int unsigned OW   = level_width(W, L);
  localparam logic [OW-1:0] HALF = OW'(TAPS / 2);

  if (!taps_ok(TAPS)) begin : g_taps_check
    $error("fir_avg_pipe: TAPS must be a power of two in 2..64");
  end

  logic            accept;
  logic            complete;
  logic            load_out;
  logic [W-1:0]    taps [TAPS];
  logic [TAPS*W-1:0] taps_flat;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            full_q;
  vstage_t         vpipe [L];
  logic            out_valid_q;
  out_mode_e       mode_q;
  logic [OW-1:0]   sum_l;
  logic [OW-1:0]   rounded;

  assign accept   = bus.in_valid && !bus.flush;
  assign complete = accept && (count >= CW'(TAPS - 1));
  // Flush on the same edge as a finishing result must leave out_data untouched.
  assign load_out = vpipe[L-1].valid && !bus.flush;

  // Sample delay line, tap0 newest; cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int unsigned i = 0; i < TAPS; i++) taps[i] <= '0;
    end else if (accept) begin
      taps[0] <= bus.in_data;
      for (int unsigned i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
    end
  end

  // Flatten the delay line for the first tree level.
  always_comb begin
    taps_flat = '0;
    for (int unsigned i = 0; i < TAPS; i++) taps_flat[i*W +: W] = taps[i];
  end

  // Saturating fill count.
  always_comb begin
    count_next = count;
    if (accept && (count != CW'(TAPS))) count_next = count + 1'b1;
  end

  // Fill counter and registered window-full flag.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      count  <= count_next;
      full_q <= (count_next == CW'(TAPS));
    end
  end

  // Valid pipeline tracking tree data; stage 0 loads alongside the delay line.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int unsigned i = 0; i < L; i++) vpipe[i] <= '{valid: 1'b0, mode: MODE_SUM};
      out_valid_q <= 1'b0;
    end else begin
      vpipe[0] <= '{valid: complete, mode: out_mode_e'(bus.avg_mode)};
      for (int unsigned i = 1; i < L; i++) vpipe[i] <= vpipe[i-1];
      out_valid_q <= vpipe[L-1].valid;
    end
  end

  // Adder tree: inner levels recompute freely, the final level only loads for a valid result.
  for (genvar j = 1; j <= L; j++) begin : g_lvl
    localparam int unsigned IW    = level_width(W, j - 1);
    localparam int unsigned PAIRS = TAPS >> j;
    logic [2*PAIRS*IW-1:0]   din;
    logic [PAIRS*(IW+1)-1:0] sum;
    logic                    en;

    if (j == 1) begin : g_first
      assign din = taps_flat;
    end else begin : g_next
      assign din = g_lvl[j-1].sum;
    end

    if (j == L) begin : g_last
      assign en = load_out;
    end else begin : g_inner
      assign en = 1'b1;
    end

    fir_add_level #(.IW(IW), .PAIRS(PAIRS)) u_level (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .din   (din),
      .dout  (sum)
    );
  end

  assign sum_l = g_lvl[L].sum;

  // Output mode travels with the result that owns the final tree register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_SUM;
    end else if (load_out) begin
      mode_q <= vpipe[L-1].mode;
    end
  end

  // Rounding is applied after the final register so the tree stays uniform;
  // both inputs are held registers, so out_data still holds between results.
  assign rounded         = sum_l + HALF;
  assign bus.out_data    = (mode_q == MODE_AVG) ? (rounded >> L) : sum_l;
  assign bus.out_valid   = out_valid_q;
  assign bus.window_full = full_q;

endmodule

// File: tb/tb_fir_avg_pipe.sv
// Directed self-checking bench for fir_avg_pipe (W=16, TAPS=4).
module tb_fir_avg_pipe;
  import fir_avg_pkg::*;

  localparam int unsigned W    = 16;
  localparam int unsigned TAPS = 4;
  localparam int unsigned L    = 2;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fir_avg_pipe_if #(.W(W), .TAPS(TAPS)) bus ();

  fir_avg_pipe #(.W(W), .TAPS(TAPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic           v;
    logic [W-1:0]   d;
    logic           m;
    logic           f;
    logic           ev;
    logic [W+L-1:0] ed;
    logic           ef;
  } vec_t;

  vec_t tbl [$];
  int tests = 0;
  int fails = 0;

  function automatic void add(input logic v, input logic [W-1:0] d, input logic m,
                              input logic f, input logic ev, input logic [W+L-1:0] ed,
                              input logic ef);
    vec_t r;
    r = '{v: v, d: d, m: m, f: f, ev: ev, ed: ed, ef: ef};
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at a falling edge and wait to the next falling edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic m, input logic f);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.avg_mode = m;
    bus.flush    = f;
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [W+L-1:0] ed,
                           input logic ef);
    check({tag, ".out_valid"},   32'(bus.out_valid),   32'(ev));
    check({tag, ".out_data"},    32'(bus.out_data),    32'(ed));
    check({tag, ".window_full"}, 32'(bus.window_full), 32'(ef));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.avg_mode = 1'b0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0, '0, 1'b0);
    reset = 1'b0;

    // fill 1..4 sum, then 5 avg, then 1..4 avg with bubbles draining
    add(1, 16'd1, 0, 0,  0, 18'd0, 0);
    add(1, 16'd2, 0, 0,  0, 18'd0, 0);
    add(1, 16'd3, 0, 0,  0, 18'd0, 0);
    add(1, 16'd4, 0, 0,  0, 18'd0, 1);
    add(1, 16'd5, 1, 0,  0, 18'd0, 1);
    add(0, 16'd0, 0, 0,  1, 18'd10, 1);
    add(1, 16'd1, 1, 0,  1, 18'd4, 1);
    add(1, 16'd2, 1, 0,  0, 18'd4, 1);
    add(1, 16'd3, 1, 0,  1, 18'd3, 1);
    add(1, 16'd4, 1, 0,  1, 18'd3, 1);
    add(0, 16'd0, 0, 0,  1, 18'd3, 1);
    add(0, 16'd0, 0, 0,  1, 18'd3, 1);
    add(0, 16'd0, 0, 0,  0, 18'd3, 1);
    // full-scale samples: sums through the transition, then max sum and max average
    add(1, 16'hFFFF, 0, 0,  0, 18'd3, 1);
    add(1, 16'hFFFF, 0, 0,  0, 18'd3, 1);
    add(1, 16'hFFFF, 0, 0,  1, 18'h10008, 1);
    add(1, 16'hFFFF, 0, 0,  1, 18'h20005, 1);
    add(1, 16'hFFFF, 1, 0,  1, 18'h30001, 1);
    add(0, 16'd0, 0, 0,  1, 18'h3FFFC, 1);
    add(0, 16'd0, 0, 0,  1, 18'h0FFFF, 1);
    add(0, 16'd0, 0, 0,  0, 18'h0FFFF, 1);
    // flush, then fill with bubbles interleaved
    add(0, 16'd0, 0, 1,  0, 18'h0FFFF, 0);
    add(1, 16'd1, 0, 0,  0, 18'h0FFFF, 0);
    add(0, 16'd0, 0, 0,  0, 18'h0FFFF, 0);
    add(0, 16'd0, 0, 0,  0, 18'h0FFFF, 0);
    add(1, 16'd2, 0, 0,  0, 18'h0FFFF, 0);
    add(1, 16'd3, 0, 0,  0, 18'h0FFFF, 0);
    add(0, 16'd0, 0, 0,  0, 18'h0FFFF, 0);
    add(1, 16'd4, 0, 0,  0, 18'h0FFFF, 1);
    add(0, 16'd0, 0, 0,  0, 18'h0FFFF, 1);
    add(0, 16'd0, 0, 0,  1, 18'd10, 1);
    add(0, 16'd0, 0, 0,  0, 18'd10, 1);
    // flush wins over a simultaneous sample; window needs four fresh samples
    add(0, 16'd0, 0, 1,  0, 18'd10, 0);
    add(1, 16'd1, 0, 0,  0, 18'd10, 0);
    add(1, 16'd2, 0, 0,  0, 18'd10, 0);
    add(1, 16'd3, 0, 0,  0, 18'd10, 0);
    add(1, 16'd4, 0, 1,  0, 18'd10, 0);
    add(1, 16'd5, 0, 0,  0, 18'd10, 0);
    add(1, 16'd6, 0, 0,  0, 18'd10, 0);
    add(1, 16'd7, 0, 0,  0, 18'd10, 0);
    add(1, 16'd8, 0, 0,  0, 18'd10, 1);
    add(0, 16'd0, 0, 0,  0, 18'd10, 1);
    add(0, 16'd0, 0, 0,  1, 18'd26, 1);
    // flush discards a result in flight
    add(1, 16'd9, 0, 0,  0, 18'd26, 1);
    add(0, 16'd0, 0, 1,  0, 18'd26, 0);
    add(0, 16'd0, 0, 0,  0, 18'd26, 0);
    add(0, 16'd0, 0, 0,  0, 18'd26, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].f);
      check_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ef);
    end

    // reset while a result is in flight; the sample offered with reset is dropped
    drive(1, 16'd1, 0, 0);
    drive(1, 16'd2, 0, 0);
    drive(1, 16'd3, 0, 0);
    drive(1, 16'd4, 0, 0);
    check_all("inflight.pre", 1'b0, 18'd26, 1'b1);
    reset = 1'b1;
    drive(1, 16'd7, 0, 0);
    check_all("inflight.reset", 1'b0, 18'd0, 1'b0);
    reset = 1'b0;
    drive(0, 16'd0, 0, 0);
    check_all("inflight.late1", 1'b0, 18'd0, 1'b0);
    drive(0, 16'd0, 0, 0);
    check_all("inflight.late2", 1'b0, 18'd0, 1'b0);
    drive(1, 16'd1, 0, 0);
    drive(1, 16'd1, 0, 0);
    drive(1, 16'd1, 0, 0);
    check("refill.three_not_full", 32'(bus.window_full), 32'd0);
    drive(1, 16'd1, 1, 0);
    check("refill.four_full", 32'(bus.window_full), 32'd1);
    drive(0, 16'd0, 0, 0);
    drive(0, 16'd0, 0, 0);
    check_all("refill.avg", 1'b1, 18'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
